vedic_mac_accum: RTL and testbench

//  Downstream consumer of the 3x3 Vedic multiplier (Multiplier: A[2:0], B[2:0] -> R[5:0]).
//  - Accepts a stream of 3-bit operand pairs over a valid/ready handshake.
//  - Registers each pair and multiplies it with one internal Multiplier instance.
//  - Accumulates COUNT products per frame.
//  - Presents the frame sum on a valid/ready output port.
//  - Sits between the operand source and any dot-product / filter consumer.

---
 rtl/vedic_mac_accum.sv | 142 ++++++++++++++
 tb/tb_vedic_mac_accum.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vedic_mac_accum.sv
// Frame multiply-accumulate built on a 3x3 Vedic (Urdhva-Tiryagbhyam) multiplier with valid/ready ports.
// Optional build macro ACC_SAT_EN: clamp the accumulator at 2^ACC_W-1 on overflow instead of wrapping.

module vedic_mul3 (
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [5:0] r
);
    logic [1:0] col1_s;
    logic [2:0] col2_s;
    logic [2:0] col3_s;
    logic [1:0] col4_s;

    // Vertical/crosswise columns, each column's carry rippling into the next.
    always_comb begin
        col1_s = {1'b0, a[1] & b[0]} + {1'b0, a[0] & b[1]};
        col2_s = {2'b00, a[2] & b[0]} + {2'b00, a[1] & b[1]} + {2'b00, a[0] & b[2]}
               + {2'b00, col1_s[1]};
        col3_s = {2'b00, a[2] & b[1]} + {2'b00, a[1] & b[2]} + {1'b0, col2_s[2:1]};
        col4_s = {1'b0, a[2] & b[2]} + col3_s[2:1];
        r      = {col4_s, col3_s[0], col2_s[0], col1_s[0], a[0] & b[0]};
    end
endmodule

module vedic_mac_accum #(
    parameter int ACC_W = 8,
    parameter int COUNT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       a,
    input  logic [2:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             ovf
);
    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    typedef enum logic [1:0] {
        S_ACC   = 2'd0,
        S_FLUSH = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t           state_r, state_next_s;
    logic             in_ready_r, out_valid_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       a_r, b_r;
    logic             p_vld_r;
    logic [ACC_W-1:0] acc_r, acc_add_s;
    logic             ovf_r, carry_s;
    logic [5:0]       prod_s;
    logic [ACC_W:0]   sum_s;
    logic             accept_s, handoff_s;

    vedic_mul3 u_mul (
        .a (a_r),
        .b (b_r),
        .r (prod_s)
    );

    assign accept_s  = in_valid && in_ready_r;
    assign handoff_s = out_valid_r && out_ready;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = acc_r;
    assign ovf       = ovf_r;

    // Next-state logic for the accept / flush / output frame sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_ACC: begin
                if (accept_s && (cnt_r == CNT_LAST)) state_next_s = S_FLUSH;
                else                                 state_next_s = S_ACC;
            end
            S_FLUSH: state_next_s = S_OUT;
            S_OUT: begin
                if (handoff_s) state_next_s = S_ACC;
                else           state_next_s = S_OUT;
            end
            default: state_next_s = S_ACC;
        endcase
    end

    // State register; handshake flags are registered from the next state so they track it exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_ACC;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == S_ACC);
            out_valid_r <= (state_next_s == S_OUT);
        end
    end

    // Accumulator update with overflow detection; saturating build pins acc at full scale.
    always_comb begin
        sum_s   = {1'b0, acc_r} + (ACC_W + 1)'(prod_s);
        carry_s = sum_s[ACC_W];
`ifdef ACC_SAT_EN
        if (carry_s || ovf_r) acc_add_s = {ACC_W{1'b1}};
        else                  acc_add_s = sum_s[ACC_W-1:0];
`else
        acc_add_s = sum_s[ACC_W-1:0];
`endif
    end

    // Operand capture, frame counting and accumulation pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= 3'd0;
            b_r     <= 3'd0;
            p_vld_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            acc_r   <= {ACC_W{1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            p_vld_r <= accept_s;
            if (accept_s) begin
                a_r <= a;
                b_r <= b;
            end
            if (handoff_s)     cnt_r <= {CNT_W{1'b0}};
            else if (accept_s) cnt_r <= cnt_r + CNT_W'(1);
            // A product is never pending during the output handoff, so the two cannot collide.
            if (handoff_s) begin
                acc_r <= {ACC_W{1'b0}};
                ovf_r <= 1'b0;
            end else if (p_vld_r) begin
                acc_r <= acc_add_s;
                ovf_r <= ovf_r | carry_s;
            end
        end
    end
endmodule

// File: tb/tb_vedic_mac_accum.sv
// Randomized self-checking bench for vedic_mac_accum; frame sums predicted from plain integer arithmetic.
`timescale 1ns/1ps
module tb_vedic_mac_accum;
    localparam int ACC_W = 8;
    localparam int COUNT = 8;
    localparam int MAXV  = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       a = 3'd0;
    logic [2:0]       b = 3'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] result;
    logic             ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int fa[COUNT];
    int fb[COUNT];

    vedic_mac_accum #(.ACC_W(ACC_W), .COUNT(COUNT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pair and hold it until an edge accepts it; returns just after that edge.
    task automatic send_pair(input int av, input int bv);
        int w;
        w = 0;
        in_valid = 1'b1;
        a = 3'(av);
        b = 3'(bv);
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        if (w >= 20) chk("accept_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // gap_mode: 0 back-to-back, 1 one idle clk between pairs, 2 random idle clks.
    task automatic run_frame(input string name, input int gap_mode, input int hold, input bit junk);
        int total, exp_res, exp_ovf, held;
        total = 0;
        for (int i = 0; i < COUNT; i++) total += fa[i] * fb[i];
        exp_ovf = (total > MAXV) ? 1 : 0;
`ifdef ACC_SAT_EN
        exp_res = exp_ovf ? MAXV : total;
`else
        exp_res = total % (MAXV + 1);
`endif
        for (int i = 0; i < COUNT; i++) begin
            send_pair(fa[i], fb[i]);
            if (i != COUNT - 1) begin
                int g;
                g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(2, 0));
                repeat (g) tick();
            end
        end
        if (junk) begin
            in_valid = 1'b1;
            a = 3'($urandom_range(7, 0));
            b = 3'($urandom_range(7, 0));
        end
        chk({name, "_flush_ov"}, 32'(out_valid), 32'd0);
        chk({name, "_flush_ir"}, 32'(in_ready), 32'd0);
        tick();
        chk({name, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_result"}, 32'(result), 32'(exp_res));
        chk({name, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        held = 0;
        repeat (hold) begin
            tick();
            held++;
            chk({name, "_hold_ov"}, 32'(out_valid), 32'd1);
            chk({name, "_hold_res"}, 32'(result), 32'(exp_res));
            chk({name, "_hold_ir"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_post_ov"}, 32'(out_valid), 32'd0);
        chk({name, "_post_ir"}, 32'(in_ready), 32'd1);
        chk({name, "_post_res"}, 32'(result), 32'd0);
    endtask

    task automatic fill_const(input int lo_a, input int lo_b, input int hi_a, input int hi_b);
        for (int i = 0; i < COUNT; i++) begin
            fa[i] = (i < COUNT / 2) ? lo_a : hi_a;
            fb[i] = (i < COUNT / 2) ? lo_b : hi_b;
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        fill_const(1, 1, 1, 1);
        run_frame("ones", 0, 0, 1'b0);
        fill_const(7, 7, 7, 7);
        run_frame("sevens", 0, 0, 1'b0);
        fill_const(3, 5, 2, 6);
        run_frame("mixed_gap", 1, 0, 1'b0);
        fill_const(1, 1, 1, 1);
        run_frame("stall", 0, 5, 1'b1);
        fill_const(2, 3, 2, 3);
        run_frame("after_stall", 0, 0, 1'b0);

        // Reset mid-frame must discard the partial sum.
        for (int i = 0; i < 3; i++) send_pair(7, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ov", 32'(out_valid), 32'd0);
        chk("midrst_res", 32'(result), 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        chk("midrst_ir", 32'(in_ready), 32'd1);
        fill_const(2, 2, 2, 2);
        run_frame("after_rst", 0, 0, 1'b0);

        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < COUNT; i++) begin
                fa[i] = int'($urandom_range(7, 0));
                fb[i] = int'($urandom_range(7, 0));
            end
            run_frame($sformatf("rand%0d", f), 2, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
